vending_controller: RTL and testbench

VENDING_CONTROLLER -- requirements
Module: vending_controller

---
 rtl/vending_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_vending_controller.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_controller.sv
// ---------------------------------------------------------------------------
// vending_controller
//
// Coin-operated vending controller. Coins add credit, a selection vends an
// item when enough credit is held, and any remaining credit is returned as
// change one coin per cycle, largest denomination first. A cancel returns
// all credit without vending.
//
// Coin encoding (used for both inserted and returned coins):
//   2'b00 = 1, 2'b01 = 5, 2'b10 = 10, 2'b11 = 25 credit units
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   asynchronous active-high reset
//   coin_valid     in   one-cycle coin-inserted strobe
//   coin_val[1:0]  in   inserted coin code
//   sel_valid      in   one-cycle purchase request
//   sel_item[1:0]  in   requested item index
//   cancel         in   one-cycle refund request
//   dispense       out  one-cycle vend pulse
//   dispense_item  out  item being vended, valid with dispense
//   change_valid   out  one pulse per returned coin
//   change_coin    out  returned coin code, valid with change_valid
//   credit[5:0]    out  current registered credit
//   busy           out  high while vending or returning change
//   coin_reject    out  pulse the cycle after a rejected coin
//   sel_nack       out  pulse the cycle after a refused selection
// ---------------------------------------------------------------------------
module vending_controller #(
  parameter int PRICE0     = 15,
  parameter int PRICE1     = 20,
  parameter int PRICE2     = 35,
  parameter int PRICE3     = 50,
  parameter int MAX_CREDIT = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_val,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       cancel,
  output logic       dispense,
  output logic [1:0] dispense_item,
  output logic       change_valid,
  output logic [1:0] change_coin,
  output logic [5:0] credit,
  output logic       busy,
  output logic       coin_reject,
  output logic       sel_nack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  state_t     state_r;
  // One bit wider than the credit port so credit + coin cannot wrap.
  logic [6:0] credit_r;
  logic [1:0] item_r;

  logic [6:0] coin_amt_s;
  logic [6:0] coin_sum_s;
  logic       coin_fits_s;
  logic [6:0] sel_price_s;
  logic       can_buy_s;
  logic [6:0] vend_rem_s;
  logic [6:0] change_rem_s;

  // Credit value of a coin code.
  function automatic logic [6:0] coin_value(input logic [1:0] code);
    logic [6:0] v;
    case (code)
      2'b00:   v = 7'd1;
      2'b01:   v = 7'd5;
      2'b10:   v = 7'd10;
      2'b11:   v = 7'd25;
      default: v = 7'd0;
    endcase
    return v;
  endfunction

  // Price of an item index.
  function automatic logic [6:0] price_of(input logic [1:0] item);
    logic [6:0] p;
    case (item)
      2'b00:   p = 7'(PRICE0);
      2'b01:   p = 7'(PRICE1);
      2'b10:   p = 7'(PRICE2);
      2'b11:   p = 7'(PRICE3);
      default: p = 7'(PRICE3);
    endcase
    return p;
  endfunction

  // Largest coin not exceeding the amount still owed.
  function automatic logic [1:0] greedy_coin(input logic [6:0] amount);
    logic [1:0] c;
    if (amount >= 7'd25) begin
      c = 2'b11;
    end else if (amount >= 7'd10) begin
      c = 2'b10;
    end else if (amount >= 7'd5) begin
      c = 2'b01;
    end else begin
      c = 2'b00;
    end
    return c;
  endfunction

  // Arithmetic shared by the state register: coin acceptance, purchase
  // affordability, and the credit left after a vend or a returned coin.
  always_comb begin
    coin_amt_s   = coin_value(coin_val);
    coin_sum_s   = credit_r + coin_amt_s;
    coin_fits_s  = (coin_sum_s <= 7'(MAX_CREDIT));
    sel_price_s  = price_of(sel_item);
    can_buy_s    = (credit_r >= sel_price_s);
    vend_rem_s   = credit_r - price_of(item_r);
    // change_coin always holds the coin on display while in CHANGE.
    change_rem_s = credit_r - coin_value(change_coin);
  end

  // Controller state, credit and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      credit_r      <= 7'd0;
      item_r        <= 2'b00;
      dispense      <= 1'b0;
      dispense_item <= 2'b00;
      change_valid  <= 1'b0;
      change_coin   <= 2'b00;
      busy          <= 1'b0;
      coin_reject   <= 1'b0;
      sel_nack      <= 1'b0;
    end else begin
      // Pulses and strobe-qualified data default low each cycle.
      dispense      <= 1'b0;
      dispense_item <= 2'b00;
      change_valid  <= 1'b0;
      change_coin   <= 2'b00;
      busy          <= 1'b0;
      coin_reject   <= 1'b0;
      sel_nack      <= 1'b0;

      case (state_r)
        IDLE, CREDIT: begin
          if (cancel) begin
            // Cancel outranks everything; a coin in the same cycle bounces.
            coin_reject <= coin_valid;
            if (credit_r != 7'd0) begin
              state_r      <= CHANGE;
              busy         <= 1'b1;
              change_valid <= 1'b1;
              change_coin  <= greedy_coin(credit_r);
            end else begin
              state_r <= IDLE;
            end
          end else if (sel_valid) begin
            coin_reject <= coin_valid;
            if (can_buy_s) begin
              state_r       <= VEND;
              busy          <= 1'b1;
              item_r        <= sel_item;
              dispense      <= 1'b1;
              dispense_item <= sel_item;
            end else begin
              sel_nack <= 1'b1;
            end
          end else if (coin_valid) begin
            if (coin_fits_s) begin
              credit_r <= coin_sum_s;
              state_r  <= CREDIT;
            end else begin
              coin_reject <= 1'b1;
            end
          end else begin
            state_r <= state_r;
          end
        end

        VEND: begin
          coin_reject <= coin_valid;
          credit_r    <= vend_rem_s;
          if (vend_rem_s != 7'd0) begin
            state_r      <= CHANGE;
            busy         <= 1'b1;
            change_valid <= 1'b1;
            change_coin  <= greedy_coin(vend_rem_s);
          end else begin
            state_r <= IDLE;
          end
        end

        CHANGE: begin
          // The displayed coin is paid out this cycle; queue the next one.
          coin_reject <= coin_valid;
          credit_r    <= change_rem_s;
          if (change_rem_s != 7'd0) begin
            state_r      <= CHANGE;
            busy         <= 1'b1;
            change_valid <= 1'b1;
            change_coin  <= greedy_coin(change_rem_s);
          end else begin
            state_r <= IDLE;
          end
        end

        default: begin
          state_r  <= IDLE;
          credit_r <= 7'd0;
        end
      endcase
    end
  end

  assign credit = credit_r[5:0];

endmodule

// File: tb/tb_vending_controller.sv
module tb_vending_controller;

  logic       clk;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_val;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       cancel;
  logic       dispense;
  logic [1:0] dispense_item;
  logic       change_valid;
  logic [1:0] change_coin;
  logic [5:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       sel_nack;

  int errors = 0;
  int checks = 0;

  vending_controller dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_val     (coin_val),
    .sel_valid    (sel_valid),
    .sel_item     (sel_item),
    .cancel       (cancel),
    .dispense     (dispense),
    .dispense_item(dispense_item),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .credit       (credit),
    .busy         (busy),
    .coin_reject  (coin_reject),
    .sel_nack     (sel_nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int units(input logic [1:0] code);
    case (code)
      2'b00:   return 1;
      2'b01:   return 5;
      2'b10:   return 10;
      default: return 25;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_val   = code;
    step();
    coin_valid = 1'b0;
    coin_val   = 2'b00;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  // Collects the returned coins while change_valid is high (bounded).
  task automatic run_change(output int sum, output int n);
    sum = 0;
    n   = 0;
    for (int i = 0; i < 20; i++) begin
      if (change_valid) begin
        sum += units(change_coin);
        n++;
        step();
      end
    end
  endtask

  task automatic test_reset();
    logic [14:0] outs;
    rst = 1'b1;
    step();
    step();
    outs = {dispense, dispense_item, change_valid, change_coin, credit, busy, coin_reject, sel_nack};
    checks++;
    if (outs !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    rst = 1'b0;
  endtask

  task automatic test_vend_with_change();
    put_coin(2'b10);
    put_coin(2'b10);
    checks++;
    if (credit !== 6'd20) begin errors++; $display("FAIL credit_20: got %0d want 20", credit); end
    sel_valid = 1'b1;
    sel_item  = 2'd0;
    step();
    sel_valid = 1'b0;
    checks++;
    if ({dispense, dispense_item, busy, credit} !== {1'b1, 2'd0, 1'b1, 6'd20}) begin
      errors++;
      $display("FAIL vend_cycle: got disp=%0d item=%0d busy=%0d credit=%0d want 1 0 1 20", dispense, dispense_item, busy, credit);
    end
    // Coin offered while vending must bounce.
    coin_valid = 1'b1;
    coin_val   = 2'b00;
    step();
    coin_valid = 1'b0;
    checks++;
    if ({dispense, change_valid, change_coin, coin_reject, credit, busy} !== {1'b0, 1'b1, 2'b01, 1'b1, 6'd5, 1'b1}) begin
      errors++;
      $display("FAIL change_after_vend: got cv=%0d coin=%0d rej=%0d credit=%0d want 1 1 1 5", change_valid, change_coin, coin_reject, credit);
    end
    step();
    checks++;
    if ({change_valid, credit, busy, coin_reject} !== {1'b0, 6'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL idle_after_change: got cv=%0d credit=%0d busy=%0d want 0 0 0", change_valid, credit, busy);
    end
  endtask

  task automatic test_overflow();
    int sum, n;
    put_coin(2'b11);
    put_coin(2'b11);
    put_coin(2'b11);
    checks++;
    if ({coin_reject, credit} !== {1'b1, 6'd50}) begin
      errors++;
      $display("FAIL overflow_reject: got rej=%0d credit=%0d want 1 50", coin_reject, credit);
    end
    step();
    checks++;
    if (coin_reject !== 1'b0) begin errors++; $display("FAIL reject_one_cycle: got %0d want 0", coin_reject); end
    put_coin(2'b10);
    put_coin(2'b01);
    checks++;
    if ({coin_reject, credit} !== {1'b1, 6'd60}) begin
      errors++;
      $display("FAIL reject_65: got rej=%0d credit=%0d want 1 60", coin_reject, credit);
    end
    put_coin(2'b00);
    put_coin(2'b00);
    put_coin(2'b00);
    checks++;
    if ({coin_reject, credit} !== {1'b0, 6'd63}) begin
      errors++;
      $display("FAIL accept_63: got rej=%0d credit=%0d want 0 63", coin_reject, credit);
    end
    do_cancel();
    run_change(sum, n);
    checks++;
    if (sum != 63 || n != 6 || credit !== 6'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL refund_63: got sum=%0d n=%0d credit=%0d want 63 6 0", sum, n, credit);
    end
  endtask

  task automatic test_nack();
    int sum, n;
    put_coin(2'b10);
    sel_valid = 1'b1;
    sel_item  = 2'd1;
    step();
    sel_valid = 1'b0;
    checks++;
    if ({sel_nack, dispense, busy, credit} !== {1'b1, 1'b0, 1'b0, 6'd10}) begin
      errors++;
      $display("FAIL sel_nack: got nack=%0d disp=%0d busy=%0d credit=%0d want 1 0 0 10", sel_nack, dispense, busy, credit);
    end
    step();
    checks++;
    if ({sel_nack, credit} !== {1'b0, 6'd10}) begin
      errors++;
      $display("FAIL nack_one_cycle: got nack=%0d credit=%0d want 0 10", sel_nack, credit);
    end
    do_cancel();
    run_change(sum, n);
    checks++;
    if (sum != 10 || n != 1) begin errors++; $display("FAIL refund_10: got sum=%0d n=%0d want 10 1", sum, n); end
    // Cancel with nothing held is ignored.
    do_cancel();
    checks++;
    if ({change_valid, busy, credit} !== {1'b0, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL cancel_zero: got cv=%0d busy=%0d credit=%0d want 0 0 0", change_valid, busy, credit);
    end
  endtask

  task automatic load_41();
    put_coin(2'b11);
    put_coin(2'b10);
    put_coin(2'b01);
    put_coin(2'b00);
  endtask

  task automatic test_cancel_sequence();
    logic [1:0] exp_code [4];
    logic [5:0] exp_cred [4];
    exp_code = '{2'b11, 2'b10, 2'b01, 2'b00};
    exp_cred = '{6'd41, 6'd16, 6'd6, 6'd1};
    load_41();
    do_cancel();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({change_valid, change_coin, credit, busy} !== {1'b1, exp_code[k], exp_cred[k], 1'b1}) begin
        errors++;
        $display("FAIL cancel_coin%0d: got cv=%0d coin=%0d credit=%0d want 1 %0d %0d", k, change_valid, change_coin, credit, exp_code[k], exp_cred[k]);
      end
      step();
    end
    checks++;
    if ({change_valid, credit, busy} !== {1'b0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL cancel_done: got cv=%0d credit=%0d busy=%0d want 0 0 0", change_valid, credit, busy);
    end
  endtask

  task automatic test_change_ignores_inputs();
    load_41();
    do_cancel();
    coin_valid = 1'b1;
    coin_val   = 2'b01;
    sel_valid  = 1'b1;
    sel_item   = 2'd0;
    cancel     = 1'b1;
    step();
    coin_valid = 1'b0;
    sel_valid  = 1'b0;
    cancel     = 1'b0;
    checks++;
    if ({change_valid, change_coin, credit, coin_reject, sel_nack, dispense} !== {1'b1, 2'b10, 6'd16, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL change_ignore: got cv=%0d coin=%0d credit=%0d rej=%0d nack=%0d disp=%0d want 1 2 16 1 0 0", change_valid, change_coin, credit, coin_reject, sel_nack, dispense);
    end
    step();
    step();
    checks++;
    if ({change_valid, change_coin, credit} !== {1'b1, 2'b00, 6'd1}) begin
      errors++;
      $display("FAIL change_ignore_tail: got cv=%0d coin=%0d credit=%0d want 1 0 1", change_valid, change_coin, credit);
    end
    step();
    checks++;
    if ({change_valid, credit, busy} !== {1'b0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL change_ignore_done: got cv=%0d credit=%0d busy=%0d want 0 0 0", change_valid, credit, busy);
    end
  endtask

  task automatic test_reset_mid_change();
    logic [14:0] outs;
    int sum, n;
    load_41();
    do_cancel();
    step();
    checks++;
    if ({change_valid, change_coin} !== {1'b1, 2'b10}) begin
      errors++;
      $display("FAIL second_change_cycle: got cv=%0d coin=%0d want 1 2", change_valid, change_coin);
    end
    #2;
    rst = 1'b1;
    #1;
    outs = {dispense, dispense_item, change_valid, change_coin, credit, busy, coin_reject, sel_nack};
    checks++;
    if (outs !== 15'd0) begin errors++; $display("FAIL async_reset: got %h want 0", outs); end
    step();
    rst = 1'b0;
    put_coin(2'b01);
    checks++;
    if ({credit, coin_reject} !== {6'd5, 1'b0}) begin
      errors++;
      $display("FAIL coin_after_reset: got credit=%0d rej=%0d want 5 0", credit, coin_reject);
    end
    do_cancel();
    run_change(sum, n);
    checks++;
    if (sum != 5 || n != 1) begin errors++; $display("FAIL refund_5: got sum=%0d n=%0d want 5 1", sum, n); end
  endtask

  task automatic test_back_to_back();
    put_coin(2'b11);
    put_coin(2'b11);
    sel_valid = 1'b1;
    sel_item  = 2'd3;
    step();
    sel_valid = 1'b0;
    checks++;
    if ({dispense, dispense_item} !== {1'b1, 2'd3}) begin
      errors++;
      $display("FAIL vend_item3: got disp=%0d item=%0d want 1 3", dispense, dispense_item);
    end
    step();
    checks++;
    if ({change_valid, credit, busy, dispense} !== {1'b0, 6'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL exact_price_idle: got cv=%0d credit=%0d busy=%0d want 0 0 0", change_valid, credit, busy);
    end
    // Selection and coin together: coin bounces, selection refused.
    coin_valid = 1'b1;
    coin_val   = 2'b11;
    sel_valid  = 1'b1;
    sel_item   = 2'd2;
    step();
    coin_valid = 1'b0;
    sel_valid  = 1'b0;
    checks++;
    if ({coin_reject, sel_nack, credit} !== {1'b1, 1'b1, 6'd0}) begin
      errors++;
      $display("FAIL sel_beats_coin: got rej=%0d nack=%0d credit=%0d want 1 1 0", coin_reject, sel_nack, credit);
    end
    put_coin(2'b11);
    put_coin(2'b10);
    sel_valid = 1'b1;
    sel_item  = 2'd2;
    step();
    sel_valid = 1'b0;
    checks++;
    if ({dispense, dispense_item, credit} !== {1'b1, 2'd2, 6'd35}) begin
      errors++;
      $display("FAIL vend_item2: got disp=%0d item=%0d credit=%0d want 1 2 35", dispense, dispense_item, credit);
    end
    step();
    checks++;
    if ({change_valid, credit, busy} !== {1'b0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL vend_item2_idle: got cv=%0d credit=%0d busy=%0d want 0 0 0", change_valid, credit, busy);
    end
  endtask

  initial begin
    rst        = 1'b1;
    coin_valid = 1'b0;
    coin_val   = 2'b00;
    sel_valid  = 1'b0;
    sel_item   = 2'b00;
    cancel     = 1'b0;
    test_reset();
    test_vend_with_change();
    test_overflow();
    test_nack();
    test_cancel_sequence();
    test_change_ignores_inputs();
    test_reset_mid_change();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
